// File: rtl/cnn_if_pkg.sv
// Shared types and layer-1 geometry for the Conv2D image-load interface.
package cnn_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_ARM,
    ST_BUSY
  } feeder_state_e;

  localparam int L1_IMG_H     = 35;
  localparam int L1_IMG_W     = 35;
  localparam int L1_ADDR_BASE = 1;
  localparam int L1_FRAME_PIX = L1_IMG_H * L1_IMG_W;

  function automatic int frame_pix(input int h, input int w);
    return h * w;
  endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Pixel index within a frame: restarts on sof, wraps after the last pixel,
// and presents the buffer address of the pixel currently being accepted.
module frame_addr_counter #(
  parameter int FRAME_PIX = 1225,
  parameter int ADDR_W    = 16,
  parameter int ADDR_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              restart,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(ADDR_BASE);

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] cur_idx;

  // A sof pixel always lands on index 0, whatever was in progress.
  assign cur_idx = restart ? '0 : idx_q;
  assign last    = (cur_idx == LAST_IDX);
  assign addr    = BASE + cur_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (step) begin
      idx_q <= last ? '0 : cur_idx + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/conv2d_1_img_feeder.sv
// Loads one image frame into the Conv2D_1 buffer from a valid/ready pixel
// stream, then enables the layer and waits for it to consume the frame.
//
//   state | meaning
//   IDLE  | waiting for a sof pixel; non-sof pixels are dropped
//   LOAD  | writing pixels, one per accepted beat
//   GAP   | frame written, settling before layer_enable
//   ARM   | layer_enable high, waiting for img_data_rd_en to rise
//   BUSY  | layer computing, waiting for img_data_rd_en to fall
module conv2d_1_img_feeder
  import cnn_if_pkg::*;
#(
  parameter int IMG_H      = L1_IMG_H,
  parameter int IMG_W      = L1_IMG_W,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int ADDR_BASE  = L1_ADDR_BASE,
  parameter int ENABLE_GAP = 5,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic              img_data_wr_en,
  output logic [DATA_W-1:0] img_data_in,
  output logic [ADDR_W-1:0] img_data_addr,
  output logic              layer_enable,
  input  logic              img_data_rd_en,
  output logic              frame_done,
  output logic              err_sof,
  output logic              err_timeout
);

  localparam int FRAME_PIX = frame_pix(IMG_H, IMG_W);
  localparam int GAP_W     = (ENABLE_GAP > 1) ? $clog2(ENABLE_GAP) : 1;
  localparam int TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((ENABLE_GAP > 0) ? ENABLE_GAP - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  if ((longint'(FRAME_PIX) + longint'(ADDR_BASE)) > ((longint'(1) << ADDR_W) - 1))
  begin : g_addr_range_check
    $error("conv2d_1_img_feeder: frame does not fit in ADDR_W address space");
  end

  feeder_state_e     state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              le_d, done_d, err_sof_d, err_to_d;
  logic              go_gap;
  logic              accept, wr_fire, last_pix;
  logic [ADDR_W-1:0] cnt_addr;

  // Held low during reset so upstream never sees a handshake it cannot complete.
  assign pix_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  assign accept    = pix_valid & pix_ready;
  assign wr_fire   = accept & ((state_q == ST_LOAD) | pix_sof);

  frame_addr_counter #(
    .FRAME_PIX (FRAME_PIX),
    .ADDR_W    (ADDR_W),
    .ADDR_BASE (ADDR_BASE)
  ) u_addr_cnt (
    .clk     (clk),
    .rst     (rst),
    .step    (wr_fire),
    .restart (pix_sof),
    .last    (last_pix),
    .addr    (cnt_addr)
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    to_d      = to_q;
    le_d      = layer_enable;
    done_d    = 1'b0;
    err_sof_d = err_sof;
    err_to_d  = err_timeout;
    go_gap    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!pix_sof)      err_sof_d = 1'b1;
          else if (last_pix) go_gap    = 1'b1;
          else               state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (pix_sof)  err_sof_d = 1'b1;
          if (last_pix) go_gap    = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_ARM;
          le_d    = 1'b1;
          to_d    = TO_LOAD;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_ARM: begin
        if (img_data_rd_en) begin
          state_d = ST_BUSY;
        end else if (TIMEOUT != 0) begin
          if (to_q == '0) begin
            err_to_d = 1'b1;
            le_d     = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            to_d = to_q - TO_W'(1);
          end
        end
      end
      ST_BUSY: begin
        if (!img_data_rd_en) begin
          le_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero gap arms the layer straight off the last write.
    if (go_gap) begin
      if (ENABLE_GAP == 0) begin
        state_d = ST_ARM;
        le_d    = 1'b1;
        to_d    = TO_LOAD;
      end else begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      gap_q          <= '0;
      to_q           <= '0;
      img_data_wr_en <= 1'b0;
      img_data_in    <= '0;
      img_data_addr  <= ADDR_W'(ADDR_BASE);
      layer_enable   <= 1'b0;
      frame_done     <= 1'b0;
      err_sof        <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      to_q           <= to_d;
      img_data_wr_en <= wr_fire;
      layer_enable   <= le_d;
      frame_done     <= done_d;
      err_sof        <= err_sof_d;
      err_timeout    <= err_to_d;
      if (wr_fire) begin
        img_data_in   <= pix_data;
        img_data_addr <= cnt_addr;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_1_img_feeder.sv
// Scoreboarded bench for the Conv2D_1 image feeder: expected writes are queued
// as pixels are accepted and checked as the write strobes appear.
module tb_conv2d_1_img_feeder;

  localparam int IMG_H      = 35;
  localparam int IMG_W      = 35;
  localparam int NPIX       = IMG_H * IMG_W;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int ADDR_BASE  = 1;
  localparam int ENABLE_GAP = 5;
  localparam int TIMEOUT    = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              pix_ready;
  logic              img_data_wr_en;
  logic [DATA_W-1:0] img_data_in;
  logic [ADDR_W-1:0] img_data_addr;
  logic              layer_enable;
  logic              img_data_rd_en;
  logic              frame_done;
  logic              err_sof;
  logic              err_timeout;

  always #5 clk = ~clk;

  conv2d_1_img_feeder #(
    .IMG_H      (IMG_H),
    .IMG_W      (IMG_W),
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .ADDR_BASE  (ADDR_BASE),
    .ENABLE_GAP (ENABLE_GAP),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_sof        (pix_sof),
    .pix_ready      (pix_ready),
    .img_data_wr_en (img_data_wr_en),
    .img_data_in    (img_data_in),
    .img_data_addr  (img_data_addr),
    .layer_enable   (layer_enable),
    .img_data_rd_en (img_data_rd_en),
    .frame_done     (frame_done),
    .err_sof        (err_sof),
    .err_timeout    (err_timeout)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   exp_idx  = 0;
  bit   send_ok;
  time  done_time;
  time  first_acc_time;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_w;

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (img_data_wr_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL wr_unexpected: got write addr=%0d data=%0d, required no write",
                   img_data_addr, img_data_in);
        end else begin
          exp_w = exp_q.pop_front();
          if ({img_data_addr, img_data_in} !== exp_w)
            $display("FAIL wr_beat: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     img_data_addr, img_data_in, exp_w[ADDR_W+DATA_W-1:DATA_W],
                     exp_w[DATA_W-1:0]);
          else
            n_pass++;
        end
      end
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic send_pixels(input int n, input int first_val, input int sof_idx,
                             input bit rnd);
    send_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      int wait_cyc = 0;
      bit v = 1'b0;
      do begin
        @(negedge clk);
        v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_valid = v;
        pix_data  = DATA_W'(first_val + i);
        pix_sof   = (i == sof_idx);
        wait_cyc++;
      end while (!(v && pix_ready === 1'b1) && wait_cyc < 400);
      if (!(v && pix_ready === 1'b1)) begin
        n_checks++;
        $display("FAIL send_stall: pixel %0d not accepted after %0d cycles, required acceptance",
                 i, wait_cyc);
        send_ok = 1'b0;
        return;
      end
      if (i == 0) first_acc_time = $time;
      if (pix_sof) exp_idx = 0;
      exp_q.push_back({ADDR_W'(ADDR_BASE + exp_idx), pix_data});
      exp_idx++;
    end
  endtask

  // Called right after the last pixel is driven; busy_len < 0 stops once armed.
  task automatic finish_frame(input int busy_len, input bit drop_valid, input bit reset_in_busy);
    int cnt = 0;
    int done0;
    bit ready_bad = 1'b0;
    bit le_bad = 1'b0;
    @(negedge clk);
    if (drop_valid) begin
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
    end
    n_checks++;
    if (pix_ready !== 1'b0 || layer_enable !== 1'b0)
      $display("FAIL gap_entry: got pix_ready=%b layer_enable=%b, required 0 0",
               pix_ready, layer_enable);
    else n_pass++;
    while (layer_enable !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
      ready_bad |= (pix_ready !== 1'b0);
    end
    n_checks++;
    if (cnt != ENABLE_GAP)
      $display("FAIL gap_len: got layer_enable after %0d cycles, required %0d", cnt, ENABLE_GAP);
    else n_pass++;
    if (busy_len < 0) return;
    done0 = done_cnt;
    img_data_rd_en = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      @(negedge clk);
      le_bad    |= (layer_enable !== 1'b1);
      ready_bad |= (pix_ready !== 1'b0);
      if (reset_in_busy && i == 2) begin
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (layer_enable !== 1'b0)
          $display("FAIL reset_async_le: got layer_enable=%b before a clock edge, required 0",
                   layer_enable);
        else n_pass++;
        n_checks++;
        if ({img_data_wr_en, frame_done, pix_ready, err_sof, err_timeout} !== 5'b0 ||
            img_data_addr !== ADDR_W'(ADDR_BASE) || img_data_in !== '0)
          $display("FAIL reset_outputs: got wr=%b done=%b rdy=%b esof=%b eto=%b addr=%0d data=%0d, required zeros addr=%0d",
                   img_data_wr_en, frame_done, pix_ready, err_sof, err_timeout,
                   img_data_addr, img_data_in, ADDR_BASE);
        else n_pass++;
        @(negedge clk);
        img_data_rd_en = 1'b0;
        rst = 1'b0;
        return;
      end
    end
    img_data_rd_en = 1'b0;
    n_checks++;
    if (le_bad || ready_bad)
      $display("FAIL hold_phase: got le_dropped=%b ready_seen=%b, required 0 0", le_bad, ready_bad);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (layer_enable !== 1'b0 || frame_done !== 1'b1)
      $display("FAIL done_edge: got layer_enable=%b frame_done=%b, required 0 1",
               layer_enable, frame_done);
    else n_pass++;
    done_time = $time;
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0 || pix_ready !== 1'b1 || done_cnt != done0 + 1)
      $display("FAIL done_pulse: got frame_done=%b pix_ready=%b pulses=%0d, required 0 1 %0d",
               frame_done, pix_ready, done_cnt - done0, 1);
    else n_pass++;
    if (drop_valid) begin
      n_checks++;
      if (exp_q.size() != 0)
        $display("FAIL writes_missing: got %0d outstanding writes, required 0", exp_q.size());
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_data = '0;
    pix_sof = 1'b0;
    img_data_rd_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({img_data_wr_en, layer_enable, frame_done, pix_ready, err_sof, err_timeout} !== 6'b0 ||
        img_data_addr !== ADDR_W'(ADDR_BASE) || img_data_in !== '0)
      $display("FAIL reset_state: got wr=%b le=%b done=%b rdy=%b addr=%0d data=%0d, required zeros addr=%0d",
               img_data_wr_en, layer_enable, frame_done, pix_ready, img_data_addr,
               img_data_in, ADDR_BASE);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pix_ready !== 1'b1)
      $display("FAIL idle_ready: got pix_ready=%b, required 1", pix_ready);
    else n_pass++;
  endtask

  task automatic test_idle_discard();
    pix_valid = 1'b1;
    pix_sof = 1'b0;
    pix_data = DATA_W'(16'h0077);
    @(negedge clk);
    pix_valid = 1'b0;
    n_checks++;
    if (err_sof !== 1'b1 || img_data_wr_en !== 1'b0)
      $display("FAIL idle_discard: got err_sof=%b wr_en=%b, required 1 0", err_sof, img_data_wr_en);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (err_sof !== 1'b0)
      $display("FAIL err_sof_clear: got err_sof=%b after reset, required 0", err_sof);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    send_pixels(NPIX, 1, 0, 1'b0);
    finish_frame(10, 1'b1, 1'b0);
    n_checks++;
    if (err_sof !== 1'b0 || err_timeout !== 1'b0)
      $display("FAIL clean_errors: got err_sof=%b err_timeout=%b, required 0 0", err_sof, err_timeout);
    else n_pass++;
  endtask

  task automatic test_random_valid();
    send_pixels(NPIX, 1, 0, 1'b1);
    finish_frame(7, 1'b1, 1'b0);
    n_checks++;
    if (img_data_addr !== ADDR_W'(ADDR_BASE + NPIX - 1))
      $display("FAIL final_addr: got %0d, required %0d", img_data_addr, ADDR_BASE + NPIX - 1);
    else n_pass++;
  endtask

  task automatic test_sof_resync();
    send_pixels(600, 1, 0, 1'b0);
    send_pixels(NPIX, 1, 0, 1'b0);
    finish_frame(10, 1'b1, 1'b0);
    n_checks++;
    if (err_sof !== 1'b1)
      $display("FAIL sof_resync: got err_sof=%b, required 1", err_sof);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt = 0;
    int done0;
    send_pixels(NPIX, 1, 0, 1'b0);
    finish_frame(-1, 1'b1, 1'b0);
    done0 = done_cnt;
    n_checks++;
    if (err_timeout !== 1'b0 || layer_enable !== 1'b1)
      $display("FAIL arm_entry: got err_timeout=%b layer_enable=%b, required 0 1",
               err_timeout, layer_enable);
    else n_pass++;
    while (layer_enable === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != TIMEOUT)
      $display("FAIL timeout_len: got %0d armed cycles, required %0d", cnt, TIMEOUT);
    else n_pass++;
    n_checks++;
    if (err_timeout !== 1'b1 || pix_ready !== 1'b1 || done_cnt != done0)
      $display("FAIL timeout_exit: got err_timeout=%b pix_ready=%b done_pulses=%0d, required 1 1 0",
               err_timeout, pix_ready, done_cnt - done0);
    else n_pass++;
  endtask

  task automatic test_reset_busy();
    send_pixels(NPIX, 1, 0, 1'b0);
    finish_frame(10, 1'b1, 1'b1);
    send_pixels(NPIX, 101, 0, 1'b0);
    finish_frame(4, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_pixels(NPIX, 1, 0, 1'b0);
    fork
      finish_frame(10, 1'b0, 1'b0);
      send_pixels(NPIX, 2000, 0, 1'b0);
    join
    n_checks++;
    if (!send_ok || first_acc_time < done_time)
      $display("FAIL b2b_order: got first accept at %0t, frame_done at %0t, required accept not earlier",
               first_acc_time, done_time);
    else n_pass++;
    finish_frame(10, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_discard();
    test_full_frame();
    test_random_valid();
    test_sof_resync();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv2d_1_img_feeder.md
Name: conv2d_1_img_feeder

Overview:
- Transmitter side of the Conv2D_1 image-load interface: drives `img_data_wr_en` / `img_data_in` / `img_data_addr` into the Conv2D_1 image buffer.
- Accepts pixels from an upstream valid/ready stream (DMA/UART bridge).
- After a full frame is written, raises `layer_enable` and holds it until Conv2D_1 signals calculation complete via `img_data_rd_en`.
- Sits between the host-side pixel source and Conv2D_1 in the full design.

Parameters:
- IMG_H, 35, image rows
- IMG_W, 35, image columns
- DATA_W, 16, pixel / `img_data_in` width
- ADDR_W, 16, `img_data_addr` width
- ADDR_BASE, 1, address of the first pixel of a frame
- ENABLE_GAP, 5, idle cycles between the last write and `layer_enable` rising
- TIMEOUT, 65535, max cycles waiting for `img_data_rd_en` to rise; 0 disables the check

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_valid  in  1  upstream pixel valid
- pix_data  in  DATA_W  upstream pixel value
- pix_sof  in  1  first pixel of a frame, qualified by pix_valid
- pix_ready  out  1  feeder can accept a pixel
- img_data_wr_en  out  1  write strobe to Conv2D_1
- img_data_in  out  DATA_W  pixel data to Conv2D_1
- img_data_addr  out  ADDR_W  buffer address to Conv2D_1
- layer_enable  out  1  Conv2D_1 enable
- img_data_rd_en  in  1  Conv2D_1 busy/reading; falling edge = frame consumed
- frame_done  out  1  one-cycle pulse when Conv2D_1 completes a frame
- err_sof  out  1  sticky: frame resynchronised by pix_sof
- err_timeout  out  1  sticky: `img_data_rd_en` never rose within TIMEOUT

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - All outputs 0, except `img_data_addr`=ADDR_BASE.
  - Counters cleared; sticky errors cleared.
  - Reset mid-operation aborts the frame immediately; `layer_enable` drops asynchronously.
- Handshake: a pixel is accepted on a rising clk edge with pix_valid & pix_ready.
- IDLE:
  - pix_ready=1.
  - Accepted pixel with pix_sof=1: go to LOAD, count=1.
  - Accepted pixel with pix_sof=0: discarded, no write, err_sof set.
- LOAD:
  - pix_ready=1.
  - Each accepted pixel produces a write one cycle later (registered): img_data_wr_en=1, img_data_in=pix_data, img_data_addr=ADDR_BASE+index, with index 0..IMG_H*IMG_W-1.
  - Cycles with no accepted pixel: img_data_wr_en=0; addr and data hold their last values.
  - pix_sof on a pixel that is not the first: err_sof set, index restarts at 0, that pixel is written to ADDR_BASE.
  - On acceptance of pixel IMG_H*IMG_W-1: go to GAP. pix_ready drops in the same cycle the last write is presented.
- GAP:
  - pix_ready=0.
  - Counts ENABLE_GAP cycles, then goes to ARM.
- ARM:
  - layer_enable=1, then wait for img_data_rd_en=1, then go to BUSY.
  - If TIMEOUT≠0 and TIMEOUT cycles elapse first: err_timeout set, layer_enable=0, return to IDLE without frame_done.
- BUSY:
  - layer_enable stays 1.
  - On img_data_rd_en falling (sampled 1 then 0): layer_enable=0 and frame_done=1 in the next cycle, then go to IDLE.
- img_data_rd_en already high on entry to ARM: go to BUSY next cycle.
- Address arithmetic is modulo 2^ADDR_W. IMG_H*IMG_W+ADDR_BASE must fit in ADDR_W; a static check rejects the configuration otherwise.
- pix_ready is 0 in GAP, ARM and BUSY; upstream back-pressures.
- Latency from pixel acceptance to write strobe: exactly 1 cycle.
- Throughput: 1 pixel/cycle.

Decomposition:
- Shared package `cnn_if_pkg`:
  - state enum (IDLE, LOAD, GAP, ARM, BUSY)
  - IMG_H/IMG_W/ADDR_BASE defaults for layer 1
  - frame-size localparam
- One natural sub-module: `frame_addr_counter` (index counter with sof restart, last-pixel flag, address = base + index).
- FSM and output registers remain in the top module.

Test Plan:
- Continuous stream of 1225 pixels, values 1..1225, sof on the first -> 1225 writes, addr 1..1225, data==addr. layer_enable rises 5 cycles after the last write. Model pulses rd_en high 10 cycles then low -> layer_enable low and frame_done pulse one cycle after rd_en falls.
- pix_valid toggled randomly (~50%) -> writes only on accepted pixels, no address gaps or duplicates, final addr 1225.
- pix_sof reasserted at pixel 600 -> err_sof=1, addr restarts at 1, frame completes after 1225 further pixels.
- Model never raises rd_en, TIMEOUT=100 -> err_timeout=1 after 100 ARM cycles, layer_enable=0, state IDLE, no frame_done.
- rst pulsed during BUSY -> layer_enable drops without waiting for a clock edge, all outputs at reset values. A new frame then loads correctly from addr 1.
- Two back-to-back frames -> second frame accepted only after frame_done. pix_ready=0 throughout GAP, ARM and BUSY.
